decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  instr is valid this cycle.
REQ-005 in_ready  output  1  stage can accept instr this cycle.
REQ-006 instr  input  32  MIPS instruction word.
REQ-007 out_valid  output  1  decoded operands valid for the ALU.
REQ-008 out_ready  input  1  ALU consumes outputs this cycle.
REQ-009 opcode  output  6  instr[31:26] of the held instruction.
REQ-010 funct  output  6  instr[5:0] of the held instruction.
REQ-011 busA  output  32  operand A.
REQ-012 busB  output  32  operand B.
REQ-013 dest  output  5  destination register number.
REQ-014 wb_en  input  1  register write enable.
REQ-015 wb_addr  input  5  register write address.
REQ-016 wb_data  input  32  register write data.

Function
REQ-017 SHALL contain 32 x 32-bit registers; register 0 reads 0 always; writes to address 0 SHALL be ignored.
REQ-018 SHALL write reg[wb_addr] <= wb_data on clk when wb_en=1 and rst=0, independent of the handshake.
REQ-019 SHALL use rs=instr[25:21], rt=instr[20:16], rd=instr[15:11], imm=instr[15:0].
REQ-020 Accept = in_valid && in_ready; in_ready SHALL be combinational: !out_valid || out_ready.
REQ-021 On accept, the next cycle SHALL have out_valid=1 with opcode, funct, busA, busB and dest captured from that instr (latency 1 cycle).
REQ-022 busA SHALL be reg[rs] sampled at accept.
REQ-023 For opcode 000000: busB=reg[rt], dest=rd.
REQ-024 For opcode 001000 (addi): busB=sign-extended imm, dest=rt.
REQ-025 For any other opcode: busB=reg[rt], dest=0.
REQ-026 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; later writebacks SHALL NOT alter the held busA/busB.
REQ-027 out_valid && out_ready && !accept SHALL clear out_valid next cycle; out_valid && out_ready && accept SHALL load the new instr with no bubble (full throughput).
REQ-028 When out_valid=0, opcode/funct/busA/busB/dest SHALL retain their last values.

Reset
REQ-029 With rst=1 at a clk edge: out_valid=0, opcode=0, funct=0, busA=0, busB=0, dest=0, all registers 0.
REQ-030 Reset mid-stall SHALL discard the held instruction; in_ready SHALL be 1 in the first cycle after reset.
REQ-031 wb_en and accept SHALL be ignored during reset.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN: when defined, an accept in the same cycle as wb_en=1 with wb_addr==rs (or rt) and wb_addr!=0 SHALL capture wb_data for that operand.
REQ-033 Without REGFILE_BYPASS_EN, that operand SHALL capture the pre-write register value; the write still completes.

Verification
REQ-034 Reset, then write reg 5=0x00000007 and reg 6=0x00000003; accept instr 0x00A63820 (add $7,$5,$6) -> next cycle: out_valid=1, opcode=0, funct=0x20, busA=7, busB=3, dest=7.
REQ-035 Accept addi 0x20A8FFFF ($8=$5+(-1)) -> busA=7, busB=0xFFFFFFFF, dest=8, opcode=0x08.
REQ-036 Hold out_ready=0 for 3 cycles after accept while writing reg 5=0x99 -> in_ready=0, outputs unchanged with busA=7; then out_ready=1 with in_valid=1 -> the next instr is loaded with no bubble.
REQ-037 Same-cycle wb_en=1, wb_addr=5, wb_data=0x1234 and accept of an add reading $5 -> busA=0x1234 with REGFILE_BYPASS_EN defined, else the old value 7; reg 5 reads 0x1234 afterwards in both builds.
REQ-038 Write wb_addr=0, wb_data=0xFFFFFFFF, then accept an add reading $0 -> busA=0.
REQ-039 Assert rst while stalled with out_valid=1 -> next cycle out_valid=0, all outputs 0, in_ready=1, and reg 5 reads 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake, decoded-operand and writeback signals of the decode stage.
// master = instruction source / ALU / writeback side, slave = decode_stage.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] busA;
  logic [31:0] busB;
  logic [4:0]  dest;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport master (
    output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, opcode, funct, busA, busB, dest
  );

  modport slave (
    input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, opcode, funct, busA, busB, dest
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: 32x32 register file, operand fetch and a one-deep output
// register with valid/ready handshake. Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback.
module decode_stage (
  input  logic                 clk,
  input  logic                 rst,
  decode_stage_if.slave        bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [31:0] r_regs [0:31];
  logic        r_out_valid;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic [31:0] r_busa;
  logic [31:0] r_busb;
  logic [4:0]  r_dest;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_wb_live;
  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic        w_byp_rs;
  logic        w_byp_rt;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_busb;
  logic [4:0]  w_dest;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_wb_live  = bus.wb_en && (bus.wb_addr != 5'd0);

  assign w_opcode = bus.instr[31:26];
  assign w_rs     = bus.instr[25:21];
  assign w_rt     = bus.instr[20:16];
  assign w_rd     = bus.instr[15:11];
  assign w_imm    = bus.instr[15:0];
  assign w_funct  = bus.instr[5:0];

`ifdef REGFILE_BYPASS_EN
  assign w_byp_rs = w_wb_live && (bus.wb_addr == w_rs);
  assign w_byp_rt = w_wb_live && (bus.wb_addr == w_rt);
`else
  assign w_byp_rs = 1'b0;
  assign w_byp_rt = 1'b0;
`endif

  // Operand A read port, with optional writeback forwarding
  always_comb begin
    w_rs_val = 32'd0;
    if (w_byp_rs) begin
      w_rs_val = bus.wb_data;
    end else if (w_rs != 5'd0) begin
      w_rs_val = r_regs[w_rs];
    end else begin
      w_rs_val = 32'd0;
    end
  end

  // Operand B read port, with optional writeback forwarding
  always_comb begin
    w_rt_val = 32'd0;
    if (w_byp_rt) begin
      w_rt_val = bus.wb_data;
    end else if (w_rt != 5'd0) begin
      w_rt_val = r_regs[w_rt];
    end else begin
      w_rt_val = 32'd0;
    end
  end

  // Select operand B and destination from the opcode class
  always_comb begin
    w_busb = w_rt_val;
    w_dest = 5'd0;
    case (w_opcode)
      OP_RTYPE: begin
        w_busb = w_rt_val;
        w_dest = w_rd;
      end
      OP_ADDI: begin
        w_busb = sign_ext16(w_imm);
        w_dest = w_rt;
      end
      default: begin
        w_busb = w_rt_val;
        w_dest = 5'd0;
      end
    endcase
  end

  // Register file: cleared by reset, register 0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wb_live) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Output register: load on accept, drop valid when consumed, hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_opcode    <= 6'd0;
      r_funct     <= 6'd0;
      r_busa      <= 32'd0;
      r_busb      <= 32'd0;
      r_dest      <= 5'd0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_opcode    <= w_opcode;
      r_funct     <= w_funct;
      r_busa      <= w_rs_val;
      r_busb      <= w_busb;
      r_dest      <= w_dest;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.opcode    = r_opcode;
  assign bus.funct     = r_funct;
  assign bus.busA      = r_busa;
  assign bus.busB      = r_busb;
  assign bus.dest      = r_dest;
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expected values are hand-decoded
// from the MIPS encodings. Build with +define+REGFILE_BYPASS_EN to check forwarding.
module tb_decode_stage;
  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] I_ADD  = 32'h00A63820; // add  $7,$5,$6
  localparam logic [31:0] I_ADDI = 32'h20A8FFFF; // addi $8,$5,-1
  localparam logic [31:0] I_LW   = 32'h8CA60004; // lw   $6,4($5)
  localparam logic [31:0] I_ADD0 = 32'h00063820; // add  $7,$0,$6

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    tick();
    bus.wb_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", bus.in_ready); end
    vectors++; if ({bus.opcode, bus.funct, bus.dest} !== 17'd0) begin errors++; $display("FAIL rst_fields got %h exp 0", {bus.opcode, bus.funct, bus.dest}); end
    vectors++; if ({bus.busA, bus.busB} !== 64'd0) begin errors++; $display("FAIL rst_bus got %h exp 0", {bus.busA, bus.busB}); end
  endtask

  task automatic test_add();
    write_reg(5'd5, 32'h00000007);
    write_reg(5'd6, 32'h00000003);
    bus.out_ready = 1'b1;
    bus.instr     = I_ADD;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b exp 1", bus.out_valid); end
    vectors++; if (bus.opcode !== 6'h00) begin errors++; $display("FAIL add_opcode got %h exp 00", bus.opcode); end
    vectors++; if (bus.funct !== 6'h20) begin errors++; $display("FAIL add_funct got %h exp 20", bus.funct); end
    vectors++; if (bus.busA !== 32'd7) begin errors++; $display("FAIL add_busA got %h exp 7", bus.busA); end
    vectors++; if (bus.busB !== 32'd3) begin errors++; $display("FAIL add_busB got %h exp 3", bus.busB); end
    vectors++; if (bus.dest !== 5'd7) begin errors++; $display("FAIL add_dest got %0d exp 7", bus.dest); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b exp 0", bus.out_valid); end
    vectors++; if (bus.busA !== 32'd7 || bus.dest !== 5'd7) begin errors++; $display("FAIL drain_retain got %h/%0d exp 7/7", bus.busA, bus.dest); end
  endtask

  task automatic test_addi();
    bus.instr    = I_ADDI;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b exp 1", bus.out_valid); end
    vectors++; if (bus.opcode !== 6'h08) begin errors++; $display("FAIL addi_opcode got %h exp 08", bus.opcode); end
    vectors++; if (bus.busA !== 32'd7) begin errors++; $display("FAIL addi_busA got %h exp 7", bus.busA); end
    vectors++; if (bus.busB !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_busB got %h exp ffffffff", bus.busB); end
    vectors++; if (bus.dest !== 5'd8) begin errors++; $display("FAIL addi_dest got %0d exp 8", bus.dest); end
  endtask

  task automatic test_other_opcode();
    bus.instr    = I_LW;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.opcode !== 6'h23) begin errors++; $display("FAIL lw_opcode got %h exp 23", bus.opcode); end
    vectors++; if (bus.busB !== 32'd3) begin errors++; $display("FAIL lw_busB got %h exp 3", bus.busB); end
    vectors++; if (bus.dest !== 5'd0) begin errors++; $display("FAIL lw_dest got %0d exp 0", bus.dest); end
    tick();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    bus.instr     = I_ADD;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.wb_en   = (c == 0);
      bus.wb_addr = 5'd5;
      bus.wb_data = 32'h00000099;
      vectors++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d got %0b exp 0", c, bus.in_ready); end
      tick();
      vectors++; if (bus.out_valid !== 1'b1 || bus.busA !== 32'd7 || bus.busB !== 32'd3 || bus.dest !== 5'd7 || bus.funct !== 6'h20) begin
        errors++; $display("FAIL stall_hold c%0d got v%0b A%h B%h d%0d exp v1 A7 B3 d7", c, bus.out_valid, bus.busA, bus.busB, bus.dest);
      end
    end
    bus.wb_en     = 1'b0;
    bus.out_ready = 1'b1;
    bus.instr     = I_ADDI;
    bus.in_valid  = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b exp 1", bus.in_ready); end
    tick();
    bus.in_valid  = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1 || bus.opcode !== 6'h08 || bus.dest !== 5'd8) begin
      errors++; $display("FAIL nobubble got v%0b op%h d%0d exp v1 op08 d8", bus.out_valid, bus.opcode, bus.dest);
    end
    vectors++; if (bus.busA !== 32'h99) begin errors++; $display("FAIL nobubble_busA got %h exp 99", bus.busA); end
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] exp_a;
`ifdef REGFILE_BYPASS_EN
    exp_a = 32'h00001234;
`else
    exp_a = 32'h00000007;
`endif
    write_reg(5'd5, 32'h00000007);
    bus.wb_en    = 1'b1;
    bus.wb_addr  = 5'd5;
    bus.wb_data  = 32'h00001234;
    bus.instr    = I_ADD;
    bus.in_valid = 1'b1;
    tick();
    bus.wb_en    = 1'b0;
    vectors++; if (bus.busA !== exp_a) begin errors++; $display("FAIL bypass_busA got %h exp %h", bus.busA, exp_a); end
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.busA !== 32'h1234) begin errors++; $display("FAIL bypass_written got %h exp 1234", bus.busA); end
    tick();
  endtask

  task automatic test_reg_zero();
    write_reg(5'd0, 32'hFFFFFFFF);
    bus.wb_en    = 1'b1;
    bus.wb_addr  = 5'd0;
    bus.wb_data  = 32'hFFFFFFFF;
    bus.instr    = I_ADD0;
    bus.in_valid = 1'b1;
    tick();
    bus.wb_en    = 1'b0;
    bus.in_valid = 1'b0;
    vectors++; if (bus.busA !== 32'd0) begin errors++; $display("FAIL zero_busA got %h exp 0", bus.busA); end
    vectors++; if (bus.busB !== 32'd3) begin errors++; $display("FAIL zero_busB got %h exp 3", bus.busB); end
    tick();
  endtask

  task automatic test_reset_stall();
    bus.out_ready = 1'b0;
    bus.instr     = I_ADD;
    bus.in_valid  = 1'b1;
    tick();
    vectors++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL prestall_valid got %0b exp 1", bus.out_valid); end
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    bus.wb_en     = 1'b1;
    bus.wb_addr   = 5'd6;
    bus.wb_data   = 32'h00000055;
    tick();
    rst           = 1'b0;
    bus.wb_en     = 1'b0;
    bus.in_valid  = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rststall_valid got %0b exp 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rststall_in_ready got %0b exp 1", bus.in_ready); end
    vectors++; if ({bus.opcode, bus.funct, bus.dest, bus.busA, bus.busB} !== 81'd0) begin
      errors++; $display("FAIL rststall_outputs got %h exp 0", {bus.opcode, bus.funct, bus.dest, bus.busA, bus.busB});
    end
    bus.instr    = I_ADD;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.busA !== 32'd0) begin errors++; $display("FAIL rststall_reg5 got %h exp 0", bus.busA); end
    vectors++; if (bus.busB !== 32'd0) begin errors++; $display("FAIL rststall_reg6 got %h exp 0", bus.busB); end
  endtask

  initial begin
    vectors       = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.out_ready = 1'b0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'd0;
    test_reset();
    test_add();
    test_addi();
    test_other_opcode();
    test_stall();
    test_bypass();
    test_reg_zero();
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
